// File: rtl/grad_arb_pkg.sv
// Shared constants and FSM state type for the gradient serialiser arbiter.
package grad_arb_pkg;
  localparam int NCHAN       = 4;
  localparam int CHAN_W      = 2;
  localparam int DATA_W_DEF  = 24;
  localparam int TMO_CYC_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;
endpackage

// File: rtl/grad_serial_arb_rr_pick.sv
// Combinational round-robin picker: first full channel after last_grant, wrapping.
module rr_pick
  import grad_arb_pkg::*;
(
  input  logic [NCHAN-1:0]  full,
  input  logic [CHAN_W-1:0] last_grant,
  output logic [CHAN_W-1:0] gnt,
  output logic              gnt_vld
);
  logic [CHAN_W-1:0] idx;

  // Walk from farthest to nearest so the nearest full channel wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = NCHAN; i >= 1; i--) begin
      idx = last_grant + CHAN_W'(i);
      if (full[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/grad_serial_arb.sv
// Four-channel holding registers arbitrated round-robin onto one DAC serialiser.
// Optional busy-handshake timeout enabled by defining GRAD_ARB_TIMEOUT_EN.
module grad_serial_arb
  import grad_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_aresetn,
  input  logic [NCHAN-1:0]        req_valid_i,
  input  logic [NCHAN*DATA_W-1:0] req_data_i,
  output logic [NCHAN-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       ser_data_o,
  output logic [CHAN_W-1:0]       ser_chan_o,
  output logic                    ser_start_o,
  input  logic                    ser_busy_i,
  output logic                    update_o,
  output logic                    err_o,
  input  logic                    err_clr_i
);
  arb_state_e state, state_nxt;

  logic [NCHAN-1:0][DATA_W-1:0] hold_data;
  logic [NCHAN-1:0]             hold_full;
  logic [NCHAN-1:0]             accept, take;
  logic [CHAN_W-1:0]            last_grant, gnt;
  logic                         gnt_vld, grant_fire, done_fire, tmo_fire;

  assign req_ready_o = ~hold_full;
  assign accept      = req_valid_i & ~hold_full;
  assign grant_fire  = (state == IDLE) && gnt_vld && !ser_busy_i;
  assign done_fire   = (state == WAIT_DONE) && !ser_busy_i;
  assign take        = grant_fire ? (NCHAN'(1) << gnt) : '0;
  assign ser_start_o = (state == START);

  rr_pick u_rr_pick (
    .full       (hold_full),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_vld    (gnt_vld)
  );

  // Accept and take never coincide: accept needs empty, take needs full.
  for (genvar n = 0; n < NCHAN; n++) begin : g_hold
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
      if (!s0_axi_aresetn) begin
        hold_full[n] <= 1'b0;
        hold_data[n] <= '0;
      end else if (accept[n]) begin
        hold_full[n] <= 1'b1;
        hold_data[n] <= req_data_i[n*DATA_W +: DATA_W];
      end else if (take[n]) begin
        hold_full[n] <= 1'b0;
      end
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant_fire) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (ser_busy_i)    state_nxt = WAIT_DONE;
        else if (tmo_fire) state_nxt = IDLE;
      end
      WAIT_DONE: if (!ser_busy_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // A word landing on the done edge leaves a hold full next cycle, so it blocks LDAC.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      ser_data_o <= '0;
      ser_chan_o <= '0;
      last_grant <= CHAN_W'(NCHAN - 1);
      update_o   <= 1'b0;
    end else begin
      update_o <= done_fire && !(|hold_full) && !(|accept);
      if (grant_fire) begin
        ser_data_o <= hold_data[gnt];
        ser_chan_o <= gnt;
        last_grant <= gnt;
      end
    end
  end

`ifdef GRAD_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_fire = (state == WAIT_BUSY) && !ser_busy_i &&
                    (tmo_cnt == TMO_W'(TMO_CYC - 1));
  assign err_o    = err_q;

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == START)                         tmo_cnt <= '0;
      else if (state == WAIT_BUSY && !ser_busy_i) tmo_cnt <= tmo_cnt + TMO_W'(1);
      // Set beats clear when both happen together.
      if (tmo_fire)       err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign tmo_fire   = 1'b0;
  assign err_o      = 1'b0;
  assign unused_cfg = err_clr_i ^ (TMO_CYC == 0);
`endif
endmodule

// File: tb/tb_grad_serial_arb.sv
// Directed bench for grad_serial_arb with a simple serialiser busy model.
module tb_grad_serial_arb;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    vld = '0;
  logic [4*DW-1:0] dat = '0;
  logic [3:0]    ready;
  logic [DW-1:0] sdata;
  logic [1:0]    schan;
  logic          sstart;
  logic          sbusy = 1'b0;
  logic          upd;
  logic          err;
  logic          eclr = 1'b0;

  int total = 0;
  int bad = 0;
  int busy_len = 24;
  bit ser_auto = 1'b1;
  int upd_cnt = 0;
  int unsigned   ch_q[$];
  logic [DW-1:0] d_q[$];

  grad_serial_arb #(.DATA_W(DW), .TMO_CYC(15)) dut (
    .s0_axi_aclk    (clk),
    .s0_axi_aresetn (rst_n),
    .req_valid_i    (vld),
    .req_data_i     (dat),
    .req_ready_o    (ready),
    .ser_data_o     (sdata),
    .ser_chan_o     (schan),
    .ser_start_o    (sstart),
    .ser_busy_i     (sbusy),
    .update_o       (upd),
    .err_o          (err),
    .err_clr_i      (eclr)
  );

  always #5 clk = ~clk;

  // Grant / LDAC monitor
  always @(negedge clk) begin
    if (sstart) begin
      ch_q.push_back(32'(schan));
      d_q.push_back(sdata);
    end
    if (upd) upd_cnt++;
  end

  // Serialiser: busy for busy_len cycles, starting the edge after the start pulse
  initial begin
    forever begin
      @(negedge clk);
      if (sstart && ser_auto) begin
        @(posedge clk); #1 sbusy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 sbusy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; vld = '0; eclr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_for(input int nstart, input int nupd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ch_q.size() >= nstart && upd_cnt >= nupd && !sbusy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    repeat (8) tick();
  endtask

  task automatic test_reset;
    do_reset();
    tick();
    total++; if (ready !== 4'b1111) begin bad++; $display("FAIL reset_ready got=%b exp=1111", ready); end
    total++; if (sdata !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", sdata); end
    total++; if (schan !== 2'd0) begin bad++; $display("FAIL reset_chan got=%0d exp=0", schan); end
    total++; if (sstart !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", sstart); end
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL reset_update got=%b exp=0", upd); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_latency;
    int u0 = upd_cnt;
    int n = -1;
    busy_len = 24;
    dat[1*DW +: DW] = 24'h123456;
    vld = 4'b0010;
    tick();
    vld = '0;
    total++; if (ready !== 4'b1101) begin bad++; $display("FAIL lat_ready_low got=%b exp=1101", ready); end
    total++; if (sstart !== 1'b0) begin bad++; $display("FAIL lat_start_early got=%b exp=0", sstart); end
    tick();
    total++; if (sstart !== 1'b1) begin bad++; $display("FAIL lat_start got=%b exp=1", sstart); end
    total++; if (sdata !== 24'h123456) begin bad++; $display("FAIL lat_data got=%h exp=123456", sdata); end
    total++; if (schan !== 2'd1) begin bad++; $display("FAIL lat_chan got=%0d exp=1", schan); end
    total++; if (ready !== 4'b1111) begin bad++; $display("FAIL lat_ready_back got=%b exp=1111", ready); end
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (upd) begin n = i; break; end
    end
    total++; if (n !== 26) begin bad++; $display("FAIL lat_update_cycle got=%0d exp=26", n); end
    tick();
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL lat_update_width got=%b exp=0", upd); end
    total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL lat_update_count got=%0d exp=1", upd_cnt - u0); end
  endtask

  task automatic test_all4;
    logic [DW-1:0] exp_d[4] = '{24'hA00000, 24'hA11111, 24'hA22222, 24'hA33333};
    int q0, u0;
    bit ok;
    do_reset();
    busy_len = 3;
    q0 = ch_q.size(); u0 = upd_cnt;
    for (int i = 0; i < 4; i++) dat[i*DW +: DW] = exp_d[i];
    vld = 4'b1111;
    tick();
    vld = '0;
    total++; if (ready !== 4'b0000) begin bad++; $display("FAIL all4_ready got=%b exp=0000", ready); end
    wait_for(q0 + 4, u0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL all4_timeout got=%0d starts exp=4", ch_q.size() - q0); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (ch_q[q0+i] !== i) begin bad++; $display("FAIL all4_order[%0d] got=%0d exp=%0d", i, ch_q[q0+i], i); end
        total++; if (d_q[q0+i] !== exp_d[i]) begin bad++; $display("FAIL all4_data[%0d] got=%h exp=%h", i, d_q[q0+i], exp_d[i]); end
      end
    end
    total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL all4_updates got=%0d exp=1", upd_cnt - u0); end
  endtask

  task automatic test_round_robin;
    logic [DW-1:0] w[3] = '{24'h2A0001, 24'h2A0002, 24'h2A0003};
    int unsigned   exp_c[4] = '{2, 0, 2, 2};
    logic [DW-1:0] exp_d[4] = '{24'h2A0001, 24'h0C0FFE, 24'h2A0002, 24'h2A0003};
    int q0 = ch_q.size();
    int u0 = upd_cnt;
    int k2 = 0;
    bit sent0 = 1'b0, a0, a2, ok;
    busy_len = 3;
    dat[0*DW +: DW] = 24'h0C0FFE;
    dat[2*DW +: DW] = w[0];
    vld = 4'b0100;
    for (int c = 0; c < 100 && !(k2 == 3 && sent0); c++) begin
      a2 = vld[2] & ready[2];
      a0 = vld[0] & ready[0];
      tick();
      if (a2) k2++;
      if (a0) sent0 = 1'b1;
      vld[2] = (k2 < 3);
      if (k2 < 3) dat[2*DW +: DW] = w[k2];
      vld[0] = (k2 >= 1) && !sent0;
    end
    vld = '0;
    wait_for(q0 + 4, u0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_timeout got=%0d starts exp=4", ch_q.size() - q0); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (ch_q[q0+i] !== exp_c[i]) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, ch_q[q0+i], exp_c[i]); end
        total++; if (d_q[q0+i] !== exp_d[i]) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, d_q[q0+i], exp_d[i]); end
      end
    end
    total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL rr_updates got=%0d exp=1", upd_cnt - u0); end
  endtask

  task automatic test_back_to_back;
    int q0 = ch_q.size();
    int u0 = upd_cnt;
    bit ok;
    busy_len = 3;
    dat[3*DW +: DW] = 24'h3B0001;
    vld = 4'b1000;
    tick();
    total++; if (ready[3] !== 1'b0) begin bad++; $display("FAIL b2b_ready_after_accept got=%b exp=0", ready[3]); end
    dat[3*DW +: DW] = 24'h3B0002;
    tick();
    total++; if (ready[3] !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_grant got=%b exp=1", ready[3]); end
    total++; if (sstart !== 1'b1 || sdata !== 24'h3B0001) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/3b0001", sstart, sdata); end
    tick();
    vld = '0;
    total++; if (ready[3] !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b exp=0", ready[3]); end
    wait_for(q0 + 2, u0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d starts exp=2", ch_q.size() - q0); end
    if (ok) begin
      total++; if (d_q[q0+1] !== 24'h3B0002 || ch_q[q0+1] !== 3) begin bad++; $display("FAIL b2b_second got=%h/%0d exp=3b0002/3", d_q[q0+1], ch_q[q0+1]); end
    end
    total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL b2b_updates got=%0d exp=1", upd_cnt - u0); end
  endtask

  task automatic test_update_suppress;
    int u0 = upd_cnt;
    int q0 = ch_q.size();
    bit ok;
    busy_len = 3;
    dat[0*DW +: DW] = 24'h0D0001;
    vld = 4'b0001;
    tick();
    vld = '0;
    tick();
    total++; if (sstart !== 1'b1) begin bad++; $display("FAIL sup_start got=%b exp=1", sstart); end
    repeat (4) tick();
    dat[1*DW +: DW] = 24'h0D0002;
    vld = 4'b0010;
    tick();
    vld = '0;
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL sup_update got=%b exp=0", upd); end
    tick();
    total++; if (sstart !== 1'b1 || sdata !== 24'h0D0002) begin bad++; $display("FAIL sup_next got=%b/%h exp=1/0d0002", sstart, sdata); end
    wait_for(q0 + 2, u0 + 1, ok);
    total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL sup_updates got=%0d exp=1", upd_cnt - u0); end
  endtask

`ifdef GRAD_ARB_TIMEOUT_EN
  task automatic test_err;
    int u0 = upd_cnt;
    ser_auto = 1'b0;
    dat[1*DW +: DW] = 24'h0E0E0E;
    vld = 4'b0010;
    tick();
    vld = '0;
    tick();
    total++; if (sstart !== 1'b1) begin bad++; $display("FAIL tmo_start got=%b exp=1", sstart); end
    repeat (15) tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", err); end
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_set got=%b exp=1", err); end
    eclr = 1'b1;
    tick();
    eclr = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", err); end
    vld = 4'b0100;
    tick();
    vld = '0;
    tick();
    total++; if (sstart !== 1'b1) begin bad++; $display("FAIL tmo_idle_again got=%b exp=1", sstart); end
    repeat (14) tick();
    eclr = 1'b1;
    repeat (2) tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_set_wins got=%b exp=1", err); end
    tick();
    eclr = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_clear2 got=%b exp=0", err); end
    total++; if (upd_cnt - u0 !== 0) begin bad++; $display("FAIL tmo_no_update got=%0d exp=0", upd_cnt - u0); end
    ser_auto = 1'b1;
  endtask
`else
  task automatic test_err;
    eclr = 1'b1;
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_tied_clr got=%b exp=0", err); end
    eclr = 1'b0;
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_tied got=%b exp=0", err); end
  endtask
`endif

  task automatic test_reset_midflight;
    int q0, u0;
    busy_len = 24;
    dat[0*DW +: DW] = 24'h0F0001;
    vld = 4'b0001;
    tick();
    vld = '0;
    tick();
    q0 = ch_q.size(); u0 = upd_cnt;
    tick();
    dat[2*DW +: DW] = 24'h0F0002;
    vld = 4'b0100;
    tick();
    vld = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (ready !== 4'b1111) begin bad++; $display("FAIL mrst_ready got=%b exp=1111", ready); end
    total++; if (sdata !== '0 || schan !== 2'd0) begin bad++; $display("FAIL mrst_data got=%h/%0d exp=0/0", sdata, schan); end
    total++; if (sstart !== 1'b0 || upd !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL mrst_ctrl got=%b%b%b exp=000", sstart, upd, err); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 60 && sbusy; i++) tick();
    repeat (10) tick();
    total++; if (ch_q.size() !== q0 + 1) begin bad++; $display("FAIL mrst_no_grant got=%0d exp=%0d", ch_q.size(), q0 + 1); end
    total++; if (upd_cnt !== u0) begin bad++; $display("FAIL mrst_no_update got=%0d exp=%0d", upd_cnt, u0); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_all4();
    test_round_robin();
    test_back_to_back();
    test_update_suppress();
    test_err();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/grad_serial_arb.md
GRAD_SERIAL_ARB -- requirements
Module: grad_serial_arb

Interface
REQ-001 Parameter SHALL be: DATA_W, default 24, width of one serialiser word.
REQ-002 Parameter SHALL be: TMO_CYC, default 15, maximum cycles allowed in WAIT_BUSY when GRAD_ARB_TIMEOUT_EN is defined.
REQ-003 Ports SHALL be:
- s0_axi_aclk  in  1  sole clock.
- s0_axi_aresetn  in  1  asynchronous active-low reset.
- req_valid_i  in  4  per-channel word valid (bit0=x, 1=y, 2=z, 3=z2).
- req_data_i  in  4*DATA_W  per-channel word; channel n at [n*DATA_W +: DATA_W].
- req_ready_o  out  4  per-channel holding register empty.
- ser_data_o  out  DATA_W  word to serialiser.
- ser_chan_o  out  2  channel index of ser_data_o.
- ser_start_o  out  1  one-cycle start pulse.
- ser_busy_i  in  1  serialiser shifting.
- update_o  out  1  one-cycle DAC-update (LDAC) pulse.
- err_o  out  1  sticky timeout error.
- err_clr_i  in  1  clears err_o.

Function
REQ-004 Each channel SHALL have a one-deep holding register; transfer occurs on an edge where req_valid_i[n] and req_ready_o[n] are both high.
REQ-005 req_ready_o[n] SHALL be the registered inverse of hold-full[n], with no combinational path from req_valid_i.
REQ-006 The FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-007 IDLE -> START SHALL occur when any hold register is full and ser_busy_i=0; on that edge ser_data_o and ser_chan_o load from the granted channel, and that hold register empties.
REQ-008 ser_start_o SHALL be high exactly during START (one cycle); START -> WAIT_BUSY unconditionally.
REQ-009 WAIT_BUSY -> WAIT_DONE when ser_busy_i=1; WAIT_DONE -> IDLE when ser_busy_i=0.
REQ-010 Latency: word accepted at edge t SHALL give ser_start_o high in cycle t+2 when the FSM is IDLE and the serialiser is free.
REQ-011 Grant SHALL be round-robin: search starts at last_grant+1 and wraps modulo 4; last_grant updates on each grant.
REQ-012 update_o SHALL pulse for one cycle on the WAIT_DONE -> IDLE edge if all hold registers are empty in that cycle, so each batch of writes produces one update after its final word.
REQ-013 A word accepted in the same cycle as WAIT_DONE -> IDLE SHALL suppress update_o, because that hold register is full on the next cycle.
REQ-014 ser_data_o and ser_chan_o SHALL hold their values until the next grant.

Reset
REQ-015 On s0_axi_aresetn=0, immediately and regardless of state:
- FSM = IDLE.
- All hold registers empty, so req_ready_o = 4'b1111 after reset release.
- ser_data_o = 0, ser_chan_o = 0, ser_start_o = 0, update_o = 0, err_o = 0.
- last_grant = 3, so channel 0 wins first.
- Any in-flight word is discarded and no update_o is issued.

Configuration
REQ-016 With GRAD_ARB_TIMEOUT_EN defined:
- A counter SHALL run in WAIT_BUSY.
- If ser_busy_i stays 0 for TMO_CYC cycles, err_o SHALL set and the FSM SHALL return to IDLE without update_o.
- err_clr_i=1 SHALL clear err_o; a set in the same cycle wins over the clear.
REQ-017 Without GRAD_ARB_TIMEOUT_EN, WAIT_BUSY SHALL wait indefinitely, err_o SHALL be tied to 0, and err_clr_i SHALL be ignored.

Structure
REQ-018 Package grad_arb_pkg SHALL hold the FSM state enum, NCHAN=4, and the default DATA_W and TMO_CYC constants.
REQ-019 Round-robin selection SHALL live in combinational sub-module rr_pick, which takes a 4-bit full mask and last_grant and returns a grant index and a grant-valid flag.

Verification
REQ-020 After reset, channel 1 sends 0x123456 with the serialiser model at 24-cycle busy -> ser_start_o in cycle t+2, ser_data_o=0x123456, ser_chan_o=1, update_o one cycle after busy falls.
REQ-021 All four channels are valid in the same cycle after reset -> grant order 0,1,2,3 and exactly one update_o after channel 3 completes.
REQ-022 Channel 2 streams back-to-back while channel 0 sends one word -> grants alternate 2,0,2 and channel 2 is never granted twice while channel 0 is pending.
REQ-023 Channel 3 writes a second word while its first is still in flight -> req_ready_o[3] is low for 1 cycle after acceptance and high again after the grant; no word is lost.
REQ-024 With GRAD_ARB_TIMEOUT_EN, ser_busy_i is held at 0 -> err_o is set 15 cycles after START, FSM returns to IDLE, no update_o; err_clr_i clears err_o.
REQ-025 s0_axi_aresetn is asserted during WAIT_DONE -> all outputs go to their reset values at once, with no update_o.
